// File: rtl/aibnd_seq_pkg.sv
// Shared types and helpers for the AIB IO buffer drive sequencer.
// Pure declarations: no latency or flow-control implications.
package aibnd_seq_pkg;

  localparam int NLEG_MAX = 16;
  localparam int CURW     = $clog2(NLEG_MAX + 1);

  typedef logic [CURW-1:0] cur_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RAMP,
    RXON,
    ACTIVE,
    RAMPDN
  } seq_state_t;

  function automatic logic [NLEG_MAX-1:0] therm(input cur_t cur);
    logic [NLEG_MAX-1:0] t;
    for (int i = 0; i < NLEG_MAX; i++) begin
      t[i] = (i < int'(cur));
    end
    return t;
  endfunction

  function automatic cur_t clamp_legs(input logic [4:0] legs);
    cur_t c;
    if (int'(legs) > NLEG_MAX) c = cur_t'(NLEG_MAX);
    else                       c = cur_t'(legs);
    return c;
  endfunction

endpackage

// File: rtl/aibnd_drv_seq_if.sv
// Static config in, IO-cell controls out; master = config/controller side, slave = sequencer.
// No handshake: config levels are sampled every cycle, controls are registered.
interface aibnd_drv_seq_if #(
  parameter int NLEG = 16,
  parameter int CNTW = 8
);

  logic            cfg_tx_en;
  logic            cfg_rx_en;
  logic            cfg_rx_clk;
  logic [4:0]      cfg_legs;
  logic [CNTW-1:0] cfg_step_cyc;
  logic            cfg_wkpu;
  logic            cfg_wkpd;

  logic [NLEG-1:0] pdrv_en;
  logic [NLEG-1:0] ndrv_enb;
  logic            weak_pullupenb;
  logic            weak_pulldownen;
  logic            data_en;
  logic            clk_en;
  logic            seq_busy;
  logic            seq_done;

  modport master (
    output cfg_tx_en, cfg_rx_en, cfg_rx_clk, cfg_legs, cfg_step_cyc, cfg_wkpu, cfg_wkpd,
    input  pdrv_en, ndrv_enb, weak_pullupenb, weak_pulldownen, data_en, clk_en,
           seq_busy, seq_done
  );

  modport slave (
    input  cfg_tx_en, cfg_rx_en, cfg_rx_clk, cfg_legs, cfg_step_cyc, cfg_wkpu, cfg_wkpd,
    output pdrv_en, ndrv_enb, weak_pullupenb, weak_pulldownen, data_en, clk_en,
           seq_busy, seq_done
  );

endinterface

// File: rtl/aibnd_step_timer.sv
// Step-interval timer: tc is high on the cycle the count reaches step_cyc-1 (0 acts as 1).
// Combinational tc from a registered count; load restarts the interval; no backpressure.
module aibnd_step_timer #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [CNTW-1:0] step_cyc,
  output logic            tc
);

  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] last;

  assign last = (step_cyc == '0) ? '0 : step_cyc - CNTW'(1);

  // >= so a step_cyc reduced mid-interval terminates at once instead of wrapping.
  assign tc = (cnt >= last);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNTW'(1);
    end
  end

endmodule

// File: rtl/aibnd_drv_seq.sv
// Drive-leg ramp, weak-pull hand-off and rx enable sequencing for one AIB IO buffer.
// All outputs registered (1 cycle from config); one leg per step interval; no backpressure.
module aibnd_drv_seq
  import aibnd_seq_pkg::*;
#(
  parameter int NLEG = NLEG_MAX,
  parameter int CNTW = 8
) (
  input logic          clk,
  input logic          rst,
  aibnd_drv_seq_if.slave bus
);

  seq_state_t state;
  seq_state_t state_nxt;
  cur_t       cur;
  cur_t       cur_nxt;
  cur_t       tgt;
  logic       rx_arm;
  logic       rx_arm_nxt;
  logic       tc;
  logic       load;
  logic       idle_nxt;

  logic [NLEG-1:0] pdrv_q;
  logic [NLEG-1:0] ndrv_q;
  logic            pu_enb_q;
  logic            pd_q;
  logic            data_en_q;
  logic            clk_en_q;
  logic            busy_q;
  logic            done_q;

  // With tx off but rx kept on, the legs still ramp to zero through RAMP.
  assign tgt = bus.cfg_tx_en ? clamp_legs(bus.cfg_legs) : '0;

  assign load = (state_nxt != state) || (cur_nxt != cur);

  aibnd_step_timer #(.CNTW(CNTW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step_cyc (bus.cfg_step_cyc),
    .tc       (tc)
  );

  always_comb begin
    state_nxt  = state;
    cur_nxt    = cur;
    rx_arm_nxt = rx_arm;
    case (state)
      IDLE: begin
        cur_nxt = '0;
        if (bus.cfg_tx_en)      state_nxt = SETTLE;
        else if (bus.cfg_rx_en) state_nxt = RXON;
      end
      SETTLE: begin
        if (tc) state_nxt = RAMP;
      end
      RAMP: begin
        if (!bus.cfg_tx_en && !bus.cfg_rx_en) begin
          state_nxt = RAMPDN;
        end else begin
          if (tc && (cur < tgt))      cur_nxt = cur + cur_t'(1);
          else if (tc && (cur > tgt)) cur_nxt = cur - cur_t'(1);
          if (cur_nxt == tgt) state_nxt = RXON;
        end
      end
      RXON: begin
        if (tc) begin
          state_nxt  = ACTIVE;
          rx_arm_nxt = 1'b1;
        end
      end
      ACTIVE: begin
        if (!bus.cfg_tx_en && !bus.cfg_rx_en) state_nxt = RAMPDN;
        else if (tgt != cur)                  state_nxt = RAMP;
      end
      RAMPDN: begin
        // Re-enabling tx resumes from the present leg count, never from zero.
        if (bus.cfg_tx_en) begin
          state_nxt = RAMP;
        end else begin
          if (tc && (cur != '0)) cur_nxt = cur - cur_t'(1);
          if (cur_nxt == '0) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cur_nxt   = '0;
      end
    endcase
    if ((state_nxt == RAMPDN) || (state_nxt == IDLE)) rx_arm_nxt = 1'b0;
  end

  assign idle_nxt = (state_nxt == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      rx_arm    <= 1'b0;
      pdrv_q    <= '0;
      ndrv_q    <= '1;
      pu_enb_q  <= 1'b1;
      pd_q      <= 1'b0;
      data_en_q <= 1'b0;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      rx_arm    <= rx_arm_nxt;
      pdrv_q    <= NLEG'(therm(cur_nxt));
      ndrv_q    <= ~NLEG'(therm(cur_nxt));
      // Pull-down has priority when both pulls are requested.
      pu_enb_q  <= ~(idle_nxt && bus.cfg_wkpu && !bus.cfg_wkpd);
      pd_q      <= idle_nxt && bus.cfg_wkpd;
      data_en_q <= rx_arm_nxt && bus.cfg_rx_en && !bus.cfg_rx_clk;
      clk_en_q  <= rx_arm_nxt && bus.cfg_rx_en && bus.cfg_rx_clk;
      busy_q    <= (state_nxt == SETTLE) || (state_nxt == RAMP) ||
                   (state_nxt == RXON)   || (state_nxt == RAMPDN);
      done_q    <= (state_nxt == ACTIVE) && (cur_nxt == tgt);
    end
  end

  assign bus.pdrv_en         = pdrv_q;
  assign bus.ndrv_enb        = ndrv_q;
  assign bus.weak_pullupenb  = pu_enb_q;
  assign bus.weak_pulldownen = pd_q;
  assign bus.data_en         = data_en_q;
  assign bus.clk_en          = clk_en_q;
  assign bus.seq_busy        = busy_q;
  assign bus.seq_done        = done_q;

endmodule
